// File: rtl/daq_frame_pkg.sv
// Shared constants and types for the DCFEB frame receive path.
package daq_frame_pkg;

   localparam logic [3:0]  HDR_H_TAG = 4'hB;
   localparam logic [3:0]  HDR_L_TAG = 4'hC;
   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;

   // Encoding is exported on RX_STATE, so the codes are fixed.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_HDR_L   = 4'd1,
      ST_SAMPLES = 4'd2,
      ST_CRC     = 4'd3,
      ST_DONE    = 4'd4,
      ST_ACK     = 4'd5,
      ST_DISCARD = 4'd6
   } rx_state_e;

   typedef struct packed {
      logic hdr;
      logic len;
      logic crc;
      logic tmo;
   } rx_err_t;

endpackage

// File: rtl/crc16_word.sv
// Word-parallel CRC-16-CCITT step, MSB of the data word folded first.
// Shared with the transmitter-side CRC generator.
module crc16_word
   import daq_frame_pkg::*;
(
   input  logic [15:0] crc,
   input  logic [15:0] din,
   output logic [15:0] crc_nxt
);

   logic [15:0] c;
   logic        fb;

   // Unrolled 16-step serial LFSR.
   always_comb begin
      c  = crc;
      fb = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ din[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
      crc_nxt = c;
   end

endmodule

// File: rtl/daq_frame_rx.sv
// Frame receiver: parses header/sample/CRC words, writes samples downstream,
// flags per-frame errors and returns TXACK or NAK to the sender.
module daq_frame_rx
   import daq_frame_pkg::*;
#(
   parameter int WORDS_PER_SMP = 96,
   parameter int ACK_LEN       = 4,
   parameter int TMO_CYCLES    = 1023
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] DIN,
   input  logic        DVALID,
   input  logic        DLAST,
   input  logic [6:0]  SAMP_MAX,
   output logic [23:0] L1A_NUM,
   output logic [15:0] SMP_DATA,
   output logic        SMP_WE,
   output logic [6:0]  SMP_NUM,
   output logic [6:0]  SEQ_NUM,
   output logic        FRAME_DONE,
   output logic        FRAME_OK,
   output logic        HDR_ERR,
   output logic        LEN_ERR,
   output logic        CRC_ERR,
   output logic        TMO_ERR,
   output logic        TXACK,
   output logic        NAK,
   output logic [3:0]  RX_STATE
);

   localparam int IDLE_W = $clog2(TMO_CYCLES + 1);

   rx_state_e         state, state_nxt;
   logic [15:0]       crc_q, crc_in, crc_nxt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [6:0]        smp_cnt, seq_cnt, samp_max_q;
   logic [11:0]       l1a_h;
   logic [3:0]        ack_cnt;
   logic              frame_ok_q;
   rx_err_t           err, err_set;
   logic              err_clr, crc_fold, l1a_h_ld, l1a_ld, smp_max_ld, smp_wr, cnt_clr;
   logic              tmo_state, tmo_hit, last_word;

   assign tmo_state = (state == ST_HDR_L) || (state == ST_SAMPLES) ||
                      (state == ST_CRC)   || (state == ST_DISCARD);
   assign tmo_hit   = tmo_state && !DVALID && (idle_cnt == IDLE_W'(TMO_CYCLES - 1));
   assign last_word = (seq_cnt == 7'(WORDS_PER_SMP - 1)) && (smp_cnt == samp_max_q);

   // The H word restarts the CRC, so it folds into CRC_INIT instead of the register.
   assign crc_in = (state == ST_IDLE) ? CRC_INIT : crc_q;

   crc16_word u_crc (
      .crc     (crc_in),
      .din     (DIN),
      .crc_nxt (crc_nxt)
   );

   // Next state and per-cycle datapath strobes.
   always_comb begin
      state_nxt  = state;
      err_set    = '0;
      err_clr    = 1'b0;
      crc_fold   = 1'b0;
      l1a_h_ld   = 1'b0;
      l1a_ld     = 1'b0;
      smp_max_ld = 1'b0;
      smp_wr     = 1'b0;
      cnt_clr    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (DVALID) begin
               err_clr = 1'b1;
               if (DIN[15:12] == HDR_H_TAG) begin
                  crc_fold   = 1'b1;
                  l1a_h_ld   = 1'b1;
                  smp_max_ld = 1'b1;
                  state_nxt  = ST_HDR_L;
               end else begin
                  err_set.hdr = 1'b1;
                  state_nxt   = ST_DISCARD;
               end
               if (DLAST) begin
                  err_set.len = 1'b1;
                  state_nxt   = ST_DONE;
               end
            end
         end
         ST_HDR_L: begin
            if (DVALID) begin
               if (DIN[15:12] == HDR_L_TAG) begin
                  l1a_ld    = 1'b1;
                  crc_fold  = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = ST_SAMPLES;
               end else begin
                  err_set.hdr = 1'b1;
                  state_nxt   = ST_DISCARD;
               end
               if (DLAST) begin
                  err_set.len = 1'b1;
                  state_nxt   = ST_DONE;
               end
            end else if (tmo_hit) begin
               err_set.tmo = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         ST_SAMPLES: begin
            if (DVALID) begin
               smp_wr   = 1'b1;
               crc_fold = 1'b1;
               if (last_word) state_nxt = ST_CRC;
               if (DLAST) begin
                  err_set.len = 1'b1;
                  state_nxt   = ST_DONE;
               end
            end else if (tmo_hit) begin
               err_set.tmo = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         ST_CRC: begin
            if (DVALID) begin
               err_set.crc = (DIN != crc_q);
               if (DLAST) begin
                  state_nxt = ST_DONE;
               end else begin
                  err_set.len = 1'b1;
                  state_nxt   = ST_DISCARD;
               end
            end else if (tmo_hit) begin
               err_set.tmo = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_ACK;
         ST_ACK: begin
            if (ack_cnt == 4'(ACK_LEN - 1)) state_nxt = ST_IDLE;
         end
         ST_DISCARD: begin
            if (DVALID && DLAST) begin
               state_nxt = ST_DONE;
            end else if (tmo_hit) begin
               err_set.tmo = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Datapath registers driven by the strobes above.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         crc_q      <= CRC_INIT;
         idle_cnt   <= '0;
         smp_cnt    <= '0;
         seq_cnt    <= '0;
         samp_max_q <= '0;
         l1a_h      <= '0;
         ack_cnt    <= '0;
         frame_ok_q <= 1'b0;
         err        <= '0;
         L1A_NUM    <= '0;
         SMP_DATA   <= '0;
         SMP_WE     <= 1'b0;
         SMP_NUM    <= '0;
         SEQ_NUM    <= '0;
      end else begin
         SMP_WE <= smp_wr;
         if (crc_fold)   crc_q      <= crc_nxt;
         if (l1a_h_ld)   l1a_h      <= DIN[11:0];
         if (l1a_ld)     L1A_NUM    <= {l1a_h, DIN[11:0]};
         if (smp_max_ld) samp_max_q <= SAMP_MAX;
         if (cnt_clr) begin
            smp_cnt <= '0;
            seq_cnt <= '0;
            SMP_NUM <= '0;
            SEQ_NUM <= '0;
         end
         if (smp_wr) begin
            SMP_DATA <= DIN;
            SMP_NUM  <= smp_cnt;
            SEQ_NUM  <= seq_cnt;
            if (seq_cnt == 7'(WORDS_PER_SMP - 1)) begin
               seq_cnt <= '0;
               smp_cnt <= smp_cnt + 7'd1;
            end else begin
               seq_cnt <= seq_cnt + 7'd1;
            end
         end
         if (tmo_state && !DVALID) idle_cnt <= idle_cnt + IDLE_W'(1);
         else                      idle_cnt <= '0;
         err <= err_clr ? err_set : rx_err_t'(err | err_set);
         if (state == ST_DONE) frame_ok_q <= ~|err;
         if (state == ST_ACK) ack_cnt <= ack_cnt + 4'd1;
         else                 ack_cnt <= '0;
      end
   end

   assign FRAME_DONE = (state == ST_DONE);
   assign FRAME_OK   = (state == ST_DONE) ? ~|err : frame_ok_q;
   assign TXACK      = (state == ST_ACK) &&  frame_ok_q;
   assign NAK        = (state == ST_ACK) && !frame_ok_q;
   assign HDR_ERR    = err.hdr;
   assign LEN_ERR    = err.len;
   assign CRC_ERR    = err.crc;
   assign TMO_ERR    = err.tmo;
   assign RX_STATE   = state;

endmodule

// File: tb/tb_daq_frame_rx.sv
// Randomized frame stimulus against a word-position model of the receiver.
module tb_daq_frame_rx;
   import daq_frame_pkg::*;

   localparam int W = 96;
   localparam int ACK_LEN = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] DIN;
   logic        DVALID, DLAST;
   logic [6:0]  SAMP_MAX;
   logic [23:0] L1A_NUM;
   logic [15:0] SMP_DATA;
   logic        SMP_WE;
   logic [6:0]  SMP_NUM, SEQ_NUM;
   logic        FRAME_DONE, FRAME_OK, HDR_ERR, LEN_ERR, CRC_ERR, TMO_ERR, TXACK, NAK;
   logic [3:0]  RX_STATE;

   daq_frame_rx #(.WORDS_PER_SMP(W), .ACK_LEN(ACK_LEN), .TMO_CYCLES(1023)) dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .DVALID(DVALID), .DLAST(DLAST), .SAMP_MAX(SAMP_MAX),
      .L1A_NUM(L1A_NUM), .SMP_DATA(SMP_DATA), .SMP_WE(SMP_WE), .SMP_NUM(SMP_NUM),
      .SEQ_NUM(SEQ_NUM), .FRAME_DONE(FRAME_DONE), .FRAME_OK(FRAME_OK), .HDR_ERR(HDR_ERR),
      .LEN_ERR(LEN_ERR), .CRC_ERR(CRC_ERR), .TMO_ERR(TMO_ERR), .TXACK(TXACK), .NAK(NAK),
      .RX_STATE(RX_STATE)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic [15:0] d; bit last; } word_t;
   typedef struct { logic [15:0] d; logic [6:0] smp; logic [6:0] seq; } wr_t;
   typedef struct { bit hdr; bit len; bit crc; bit tmo; logic [23:0] l1a; } res_t;

   word_t fw[$];
   wr_t   exp_wr[$];
   res_t  exp_res[$];
   int    checks = 0, failures = 0;
   int    acks_done = 0, wr_seen = 0, tx_cycles = 0, nak_cycles = 0;
   int    ack_left = 0;
   bit    ack_ok = 0, last_ok = 0;
   logic [6:0]  last_smp = 0, last_seq = 0;
   logic [23:0] m_l1a = 0;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Byte-wise reference CRC, deliberately a different formulation from the RTL.
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
      return crc_byte(crc_byte(c, w[15:8]), w[7:0]);
   endfunction

   task automatic build_frame(input logic [11:0] h, input logic [11:0] l, input int sm);
      word_t x;
      logic [15:0] c;
      fw.delete();
      c = 16'hFFFF;
      x.last = 0;
      x.d = {4'hB, h}; fw.push_back(x); c = crc_word(c, x.d);
      x.d = {4'hC, l}; fw.push_back(x); c = crc_word(c, x.d);
      for (int i = 0; i < (sm + 1) * W; i++) begin
         x.d = 16'($urandom); fw.push_back(x); c = crc_word(c, x.d);
      end
      x.d = c; x.last = 1; fw.push_back(x);
   endtask

   // Word-position model: word 0 = H, 1 = L, then samples, then CRC.
   task automatic model_frame(input int sm, input int n_sent);
      res_t  r;
      wr_t   w;
      word_t x;
      logic [15:0] c;
      logic [11:0] h;
      int n;
      bit disc, ended;
      r.hdr = 0; r.len = 0; r.crc = 0; r.tmo = 0;
      c = 16'hFFFF; h = 0; n = (sm + 1) * W; disc = 0; ended = 0;
      for (int i = 0; i < n_sent; i++) begin
         x = fw[i];
         if (disc) begin
            if (x.last) begin ended = 1; break; end
            continue;
         end
         if (i == 0) begin
            if (x.d[15:12] != 4'hB) begin r.hdr = 1; disc = 1; end
            else begin c = crc_word(c, x.d); h = x.d[11:0]; end
         end else if (i == 1) begin
            if (x.d[15:12] != 4'hC) begin r.hdr = 1; disc = 1; end
            else begin c = crc_word(c, x.d); m_l1a = {h, x.d[11:0]}; end
         end else if (i < 2 + n) begin
            w.d = x.d; w.smp = 7'((i - 2) / W); w.seq = 7'((i - 2) % W);
            exp_wr.push_back(w);
            c = crc_word(c, x.d);
         end else begin
            if (x.d != c) r.crc = 1;
            if (!x.last) begin r.len = 1; disc = 1; continue; end
            ended = 1; break;
         end
         if (x.last) begin r.len = 1; ended = 1; break; end
      end
      if (!ended) r.tmo = 1;
      r.l1a = m_l1a;
      exp_res.push_back(r);
   endtask

   task automatic send(input int n_sent, input int gap_max, input bit sm_chg);
      for (int i = 0; i < n_sent; i++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            @(posedge CLK); #1;
            DVALID = 0; DIN = 16'($urandom); DLAST = 1'($urandom);
         end
         @(posedge CLK); #1;
         DVALID = 1; DIN = fw[i].d; DLAST = fw[i].last;
         if (sm_chg && i > 0) SAMP_MAX = 7'($urandom);
      end
      @(posedge CLK); #1;
      DVALID = 0; DLAST = 0;
   endtask

   task automatic wait_ack(input int target);
      int n = 0;
      while (acks_done < target && n < 5000) begin @(posedge CLK); n++; end
      chk("ack_wait", acks_done, target);
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic run_frame(input int sm, input int n_sent, input int gap_max, input bit sm_chg);
      int target;
      chk("idle_before_frame", RX_STATE, ST_IDLE);
      SAMP_MAX = 7'(sm);
      model_frame(sm, n_sent);
      target = acks_done + 1;
      send(n_sent, gap_max, sm_chg);
      wait_ack(target);
   endtask

   // Cycle-by-cycle comparison against the model's queues.
   always @(negedge CLK) begin
      if (RST) begin
         ack_left = 0; last_ok = 0;
      end else begin
         if (SMP_WE) begin
            if (exp_wr.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write actual=%0h required=none", SMP_DATA);
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("smp_write", {SMP_DATA, SMP_NUM, SEQ_NUM}, {w.d, w.smp, w.seq});
            end
            wr_seen++; last_smp = SMP_NUM; last_seq = SEQ_NUM;
         end
         chk("txack", TXACK, (ack_left > 0) && ack_ok);
         chk("nak", NAK, (ack_left > 0) && !ack_ok);
         tx_cycles += int'(TXACK);
         nak_cycles += int'(NAK);
         if (FRAME_DONE) begin
            if (exp_res.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               res_t r;
               bit ok;
               r = exp_res.pop_front();
               ok = !(r.hdr || r.len || r.crc || r.tmo);
               chk("err_flags", {HDR_ERR, LEN_ERR, CRC_ERR, TMO_ERR}, {r.hdr, r.len, r.crc, r.tmo});
               chk("frame_ok", FRAME_OK, ok);
               chk("l1a_num", L1A_NUM, r.l1a);
               chk("done_state", RX_STATE, ST_DONE);
               last_ok = ok; ack_ok = ok; ack_left = ACK_LEN;
            end
         end else begin
            chk("frame_ok_hold", FRAME_OK, last_ok);
            if (ack_left > 0) begin
               chk("ack_state", RX_STATE, ST_ACK);
               ack_left--;
               if (ack_left == 0) acks_done++;
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, t0, n0, p, mode, sm;
      logic [15:0] c;
      string s;
      RST = 1; DVALID = 0; DLAST = 0; DIN = 0; SAMP_MAX = 7;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_outputs", {L1A_NUM, SMP_DATA, SMP_WE, SMP_NUM, SEQ_NUM, FRAME_DONE, FRAME_OK,
                            HDR_ERR, LEN_ERR, CRC_ERR, TMO_ERR, TXACK, NAK, RX_STATE}, 80'h0);
      @(posedge CLK); #1 RST = 0;

      // Pin the reference CRC to the published CCITT-FALSE check value.
      s = "123456789"; c = 16'hFFFF;
      for (int i = 0; i < s.len(); i++) c = crc_byte(c, s[i]);
      chk("crc_ref_check", c, 16'h29B1);

      // Good frame, contiguous.
      build_frame(12'h012, 12'h345, 7);
      w0 = wr_seen; t0 = tx_cycles; n0 = nak_cycles;
      run_frame(7, fw.size(), 0, 0);
      chk("t1_l1a", L1A_NUM, 24'h012345);
      chk("t1_writes", wr_seen - w0, 768);
      chk("t1_last_wr", {last_smp, last_seq}, {7'd7, 7'd95});
      chk("t1_txack_len", tx_cycles - t0, 4);
      chk("t1_nak_len", nak_cycles - n0, 0);
      chk("t1_ok_held", FRAME_OK, 1);

      // Same frame with idle gaps.
      w0 = wr_seen; t0 = tx_cycles;
      run_frame(7, fw.size(), 50, 0);
      chk("t2_writes", wr_seen - w0, 768);
      chk("t2_txack_len", tx_cycles - t0, 4);
      chk("t2_no_tmo", TMO_ERR, 0);

      // CRC bit 0 flipped.
      fw[fw.size() - 1].d ^= 16'h0001;
      t0 = tx_cycles; n0 = nak_cycles;
      run_frame(7, fw.size(), 0, 0);
      chk("t3_crc_err", CRC_ERR, 1);
      chk("t3_nak_len", nak_cycles - n0, 4);
      chk("t3_txack_len", tx_cycles - t0, 0);

      // Truncated on sample word 400, then a good frame.
      build_frame(12'h0AA, 12'h055, 7);
      while (fw.size() > 403) void'(fw.pop_back());
      fw[402].last = 1;
      w0 = wr_seen;
      run_frame(7, fw.size(), 0, 0);
      chk("t4_writes", wr_seen - w0, 401);
      chk("t4_len_err", LEN_ERR, 1);
      build_frame(12'h123, 12'h456, 7);
      t0 = tx_cycles;
      run_frame(7, fw.size(), 0, 0);
      chk("t4_recover_tx", tx_cycles - t0, 4);
      chk("t4_len_clear", LEN_ERR, 0);

      // Bad first header word, then a good frame.
      fw.delete();
      begin
         word_t x;
         x.d = 16'hA000; x.last = 0; fw.push_back(x);
         for (int i = 0; i < 20; i++) begin
            x.d = 16'($urandom); x.last = (i == 19); fw.push_back(x);
         end
      end
      w0 = wr_seen; n0 = nak_cycles;
      run_frame(7, fw.size(), 0, 0);
      chk("t5_writes", wr_seen - w0, 0);
      chk("t5_hdr_err", HDR_ERR, 1);
      chk("t5_nak_len", nak_cycles - n0, 4);
      build_frame(12'hFED, 12'hCBA, 1);
      t0 = tx_cycles;
      run_frame(1, fw.size(), 0, 0);
      chk("t5_recover_tx", tx_cycles - t0, 4);

      // Stall after word 100.
      build_frame(12'h777, 12'h888, 7);
      n0 = nak_cycles;
      run_frame(7, 101, 0, 0);
      chk("t6_tmo_err", TMO_ERR, 1);
      chk("t6_nak_len", nak_cycles - n0, 4);

      // Randomized frames with assorted faults; SAMP_MAX scrambled mid-frame.
      for (int k = 0; k < 8; k++) begin
         sm = $urandom_range(3, 0);
         mode = $urandom_range(4, 0);
         build_frame(12'($urandom), 12'($urandom), sm);
         case (mode)
            1: fw[fw.size() - 1].d ^= 16'(1 << $urandom_range(15, 0));
            2: begin
               p = $urandom_range(fw.size() - 2, 0);
               while (fw.size() > p + 1) void'(fw.pop_back());
               fw[p].last = 1;
            end
            3: fw[1].d[15:12] = 4'h5;
            4: begin
               word_t x;
               fw[fw.size() - 1].last = 0;
               x.d = 16'($urandom); x.last = 1; fw.push_back(x);
            end
            default: ;
         endcase
         run_frame(sm, fw.size(), 3, 1);
      end

      // Largest frame: 128 samples.
      build_frame(12'h800, 12'h001, 127);
      w0 = wr_seen;
      run_frame(127, fw.size(), 0, 0);
      chk("t8_writes", wr_seen - w0, 128 * W);
      chk("t8_last_wr", {last_smp, last_seq}, {7'd127, 7'd95});

      // Reset in the middle of SAMPLES.
      build_frame(12'h321, 12'h654, 7);
      SAMP_MAX = 7;
      for (int i = 2; i < 200; i++) begin
         wr_t w;
         w.d = fw[i].d; w.smp = 7'((i - 2) / W); w.seq = 7'((i - 2) % W);
         exp_wr.push_back(w);
      end
      send(200, 0, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1;
      #1;
      chk("rst_mid_outputs", {L1A_NUM, SMP_DATA, SMP_WE, SMP_NUM, SEQ_NUM, FRAME_DONE, FRAME_OK,
                              HDR_ERR, LEN_ERR, CRC_ERR, TMO_ERR, TXACK, NAK, RX_STATE}, 80'h0);
      m_l1a = 0;
      repeat (3) @(posedge CLK);
      #1 RST = 0;
      repeat (30) @(posedge CLK);
      #1;
      chk("rst_writes_drained", exp_wr.size(), 0);
      build_frame(12'h0F0, 12'h00F, 0);
      t0 = tx_cycles;
      run_frame(0, fw.size(), 0, 0);
      chk("rst_recover_tx", tx_cycles - t0, 4);

      chk("end_wr_queue", exp_wr.size(), 0);
      chk("end_res_queue", exp_res.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/daq_frame_rx.md
Name: daq_frame_rx

Overview:
- Receiving end of the DCFEB sample-processing frame stream; checks each frame and answers with the link acknowledge (TXACK) that the sample-processing FSM waits on.
- Accepts 16-bit words qualified by a valid strobe and a last-word flag, and parses them in this order: two L1A header words, (SAMP_MAX+1) samples of WORDS_PER_SMP words each, one CRC word.
- Writes sample words to a downstream buffer, reports header, length, CRC and timeout errors, and pulses TXACK on a good frame or NAK on a bad one.
- Used in loopback test firmware and in the simulation bench.

Parameters:
- WORDS_PER_SMP, 96, words per sample (6 chips x 16 channels).
- ACK_LEN, 4, TXACK/NAK pulse width in CLK cycles (1..15).
- TMO_CYCLES, 1023, maximum consecutive idle cycles inside a frame before abort.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- DIN  in  16  frame data word
- DVALID  in  1  DIN valid this cycle
- DLAST  in  1  word is last of frame (meaningful only with DVALID)
- SAMP_MAX  in  7  last sample index; frame carries SAMP_MAX+1 samples
- L1A_NUM  out  24  {H[11:0],L[11:0]} from the header; updated when the L word is accepted
- SMP_DATA  out  16  registered sample word
- SMP_WE  out  1  SMP_DATA write strobe
- SMP_NUM  out  7  sample index of SMP_DATA
- SEQ_NUM  out  7  word index within sample of SMP_DATA
- FRAME_DONE  out  1  one-cycle pulse at end of every frame, good or bad
- FRAME_OK  out  1  valid with FRAME_DONE; held until the next FRAME_DONE
- HDR_ERR, LEN_ERR, CRC_ERR, TMO_ERR  out  1 each  sticky per frame; cleared on the first header word of the next frame
- TXACK  out  1  ACK_LEN-cycle pulse after a good frame
- NAK  out  1  ACK_LEN-cycle pulse after a bad frame
- RX_STATE  out  4  state encoding, for ChipScope

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 16'hFFFF; counters 0.
- Header format: H word DIN[15:12]=4'hB, L word DIN[15:12]=4'hC; bits [11:0] carry the L1A number.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, word-parallel, MSB first. Covers the header words and all sample words. The CRC word must equal the register value before the CRC word is folded in.
- Accepted word: a cycle with DVALID=1. With DVALID=0 the state holds and the idle counter increments.

State machine (state code in parentheses):
- IDLE (0): wait for an accepted word.
  - DIN[15:12]=B: clear error flags, init CRC, fold the word, go to HDR_L.
  - Any other value: set HDR_ERR, go to DISCARD.
- HDR_L (1):
  - DIN[15:12]=C: latch L1A_NUM, go to SAMPLES with SMP_NUM=0 and SEQ_NUM=0.
  - Otherwise: set HDR_ERR, go to DISCARD.
- SAMPLES (2): each accepted word drives SMP_WE=1 with SMP_DATA/SMP_NUM/SEQ_NUM registered, so the outputs appear one cycle after the accepted word.
  - SEQ_NUM wraps at WORDS_PER_SMP-1 and then SMP_NUM increments.
  - After word (WORDS_PER_SMP-1) of sample SAMP_MAX, go to CRC.
- CRC (3): compare the accepted word with the CRC register.
  - Mismatch sets CRC_ERR.
  - If DLAST=0, set LEN_ERR and go to DISCARD; otherwise go to DONE.
- DONE (4): single cycle; FRAME_DONE=1; FRAME_OK = no error flag set. Go to ACK.
- ACK (5): drive TXACK (good frame) or NAK (bad frame) for ACK_LEN cycles, then go to IDLE. Words arriving during ACK are ignored.
- DISCARD (6): drop words until an accepted word with DLAST=1, then go to DONE.

Boundary conditions:
- DLAST=1 on any word before the CRC state (including a header word): set LEN_ERR, go to DONE directly, skip DISCARD.
- SMP_WE still pulses for the truncating sample word.
- Idle counter reaching TMO_CYCLES in HDR_L, SAMPLES, CRC or DISCARD: set TMO_ERR, go to DONE. The counter clears on every accepted word.
- SAMP_MAX is sampled on the first header word; changes mid-frame have no effect.
- RST mid-frame: immediate return to reset values; no FRAME_DONE is generated for the aborted frame.
- Counter widths are 7 bits; SAMP_MAX=127 gives 128 samples with no overflow.

Decomposition:
- Shared package daq_frame_pkg holds:
  - HDR_H_TAG=4'hB, HDR_L_TAG=4'hC, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF;
  - the rx state encoding constants above, used by the bench decoder.
- Sub-module crc16_word: combinational next-CRC from (crc[15:0], din[15:0]). It is reused by the transmitter-side CRC generator.

Test Plan:
- Good frame, SAMP_MAX=7, WORDS_PER_SMP=96, 771 contiguous words, header B012/C345 -> L1A_NUM=24'h012345; 768 SMP_WE pulses; last write SMP_NUM=7, SEQ_NUM=95; FRAME_OK=1; TXACK high 4 cycles, NAK stays 0.
- Same frame with DVALID gaps of 0-50 cycles between words -> identical write sequence and TXACK; no TMO_ERR.
- CRC word bit 0 flipped -> CRC_ERR=1, FRAME_OK=0, NAK high 4 cycles, TXACK stays 0.
- DLAST asserted on sample word 400 -> LEN_ERR=1, FRAME_DONE one cycle later, 401 SMP_WE pulses; next good frame clears the flag and gets TXACK.
- First word 0xA000 followed by 20 words ending with DLAST -> HDR_ERR=1, no SMP_WE, NAK; then a good frame -> TXACK.
- Stream stalls 1023 cycles after word 100 -> TMO_ERR, NAK. Separately, RST asserted mid-SAMPLES -> all outputs 0, RX_STATE=0, no FRAME_DONE.
